mult_unit: RTL and testbench



---
 rtl/mult_unit_if.sv | 24 ++
 rtl/mult_unit.sv | 127 ++++++++++++
 tb/tb_mult_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mult_unit_if.sv
// Handshake and result bundle between the decoder/writeback side and mult_unit.
interface mult_unit_if #(
  parameter int unsigned W = 8
) ();
  logic                  start;
  logic signed [W-1:0]   a;
  logic signed [W-1:0]   b;
  logic                  stall;
  logic                  busy;
  logic                  done;
  logic signed [2*W-1:0] product;
  logic signed [W-1:0]   result;
  logic                  sat;

  modport master (
    output start, a, b,
    input  stall, busy, done, product, result, sat
  );

  modport slave (
    input  start, a, b,
    output stall, busy, done, product, result, sat
  );
endinterface

// File: rtl/mult_unit.sv
// Sequential signed shift-add multiplier for MULT: one multiplier bit per cycle, LSB first,
// with fixed-point scaling and saturation of the writeback result.
module mult_unit #(
  parameter int unsigned W    = 8,
  parameter int unsigned FRAC = 0
) (
  input logic        clk,
  input logic        rst,
  mult_unit_if.slave bus
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
  localparam logic signed [W-1:0] ResMax = {1'b0, {(W - 1){1'b1}}};
  localparam logic signed [W-1:0] ResMin = {1'b1, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic signed [W-1:0]   a_q, a_d, b_q, b_d;
  logic signed [2*W-1:0] acc_q, acc_d, prod_q, prod_d;
  logic signed [W-1:0]   res_q, res_d;
  logic                  sat_q, sat_d, busy_q, busy_d, done_q, done_d;

  logic                  last_bit;
  logic signed [2*W-1:0] addend, acc_nxt, scaled;
  logic [W:0]            scaled_hi;
  logic                  in_range;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StBusy;
      StBusy:  if (last_bit)  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: stall is the only combinational one, busy/done are registered copies
  always_comb begin
    bus.stall = ((state_q == StIdle) && bus.start) || (state_q == StBusy);
    busy_d    = (state_d == StBusy);
    done_d    = (state_d == StDone);
  end

  // Datapath: the MSB of b carries negative weight in two's complement, so it subtracts
  always_comb begin
    last_bit  = (cnt_q == CntW'(W - 1));
    addend    = $signed({{W{a_q[W-1]}}, a_q}) << cnt_q;
    acc_nxt   = acc_q;
    if (b_q[cnt_q]) acc_nxt = last_bit ? (acc_q - addend) : (acc_q + addend);
    scaled    = acc_nxt >>> FRAC;
    scaled_hi = scaled[2*W-1:W-1];
    in_range  = (&scaled_hi) || ~(|scaled_hi);
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    prod_d = prod_q;
    res_d  = res_q;
    sat_d  = sat_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d   = bus.a;
          b_d   = bus.b;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      StBusy: begin
        acc_d = acc_nxt;
        cnt_d = last_bit ? '0 : cnt_q + CntW'(1);
        if (last_bit) begin
          prod_d = acc_nxt;
          sat_d  = ~in_range;
          if (in_range)           res_d = scaled[W-1:0];
          else if (scaled[2*W-1]) res_d = ResMin;
          else                    res_d = ResMax;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      prod_q <= '0;
      res_q  <= '0;
      sat_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      prod_q <= prod_d;
      res_q  <= res_d;
      sat_q  <= sat_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = prod_q;
  assign bus.result  = res_q;
  assign bus.sat     = sat_q;

endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit: integer (FRAC=0) and fixed-point (FRAC=7) instances
// with a per-instance scoreboard of expected writeback values.
module tb_mult_unit;
  localparam int unsigned W = 8;
  localparam int RMax = (1 << (W - 1)) - 1;
  localparam int RMin = -(1 << (W - 1));

  typedef struct {
    logic signed [2*W-1:0] product;
    logic signed [W-1:0]   result;
    logic                  sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t sbq0[$];
  exp_t sbq1[$];

  always #5 clk = ~clk;

  mult_unit_if #(.W(W)) if0 ();
  mult_unit_if #(.W(W)) if1 ();

  mult_unit #(.W(W), .FRAC(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mult_unit #(.W(W), .FRAC(7)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  function automatic exp_t model(logic signed [W-1:0] av, logic signed [W-1:0] bv, int frac);
    exp_t                  e;
    logic signed [2*W-1:0] p;
    logic signed [2*W-1:0] s;
    int                    si;
    p         = av * bv;
    s         = p >>> frac;
    si        = int'(s);
    e.product = p;
    if (si > RMax) begin
      e.result = W'(RMax);
      e.sat    = 1'b1;
    end else if (si < RMin) begin
      e.result = W'(RMin);
      e.sat    = 1'b1;
    end else begin
      e.result = W'(si);
      e.sat    = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic g_done(int sel);
    return (sel == 0) ? if0.done : if1.done;
  endfunction

  function automatic logic g_stall(int sel);
    return (sel == 0) ? if0.stall : if1.stall;
  endfunction

  task automatic drive(int sel, logic st, logic signed [W-1:0] av, logic signed [W-1:0] bv);
    if (sel == 0) begin
      if0.start = st; if0.a = av; if0.b = bv;
    end else begin
      if1.start = st; if1.a = av; if1.b = bv;
    end
  endtask

  task automatic set_start(int sel, logic st);
    if (sel == 0) if0.start = st;
    else          if1.start = st;
  endtask

  task automatic push(int sel, logic signed [W-1:0] av, logic signed [W-1:0] bv);
    if (sel == 0) sbq0.push_back(model(av, bv, 0));
    else          sbq1.push_back(model(av, bv, 7));
  endtask

  task automatic check_out(int sel, string tag);
    exp_t e;
    int   n;
    n = (sel == 0) ? sbq0.size() : sbq1.size();
    checks++;
    assert (n != 0) else begin
      failures++;
      $error("FAIL %s_sb_empty observed=done expected=no_done", tag);
    end
    if (n != 0) begin
      e = (sel == 0) ? sbq0.pop_front() : sbq1.pop_front();
      if (sel == 0) begin
        chk({tag, "_product"}, if0.product, e.product);
        chk({tag, "_result"},  if0.result,  e.result);
        chk({tag, "_sat"},     if0.sat,     e.sat);
      end else begin
        chk({tag, "_product"}, if1.product, e.product);
        chk({tag, "_result"},  if1.result,  e.result);
        chk({tag, "_sat"},     if1.sat,     e.sat);
      end
    end
  endtask

  // Starts one op in the cycle after the call, then tracks latency and stall length
  task automatic run_op(int sel, logic signed [W-1:0] av, logic signed [W-1:0] bv, string tag);
    int stalls;
    int lat;
    @(posedge clk); #1;
    push(sel, av, bv);
    drive(sel, 1'b1, av, bv);
    #1;
    stalls = g_stall(sel) ? 1 : 0;
    lat    = 0;
    for (int c = 1; c <= int'(W) + 6 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) set_start(sel, 1'b0);
      if (g_done(sel)) begin
        lat = c;
        chk({tag, "_stall_in_done"}, g_stall(sel), 0);
        check_out(sel, tag);
      end else if (g_stall(sel)) begin
        stalls++;
      end
    end
    chk({tag, "_latency"}, lat, W + 1);
    chk({tag, "_stall_cycles"}, stalls, W + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    int d1;
    int d2;

    // Reset held with start asserted
    rst = 1'b1;
    drive(0, 1'b1, 8'sh03, 8'sh05);
    drive(1, 1'b0, 8'sh00, 8'sh00);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_busy", if0.busy, 0);
      chk("rst_done", if0.done, 0);
      chk("rst_product", if0.product, 0);
      chk("rst_result", if0.result, 0);
      chk("rst_sat", if0.sat, 0);
      chk("rst_stall_start", if0.stall, 1);
      chk("rst_stall_nostart", if1.stall, 0);
    end
    rst = 1'b0;
    set_start(0, 1'b0);
    #1;
    chk("idle_stall", if0.stall, 0);

    // Integer products and saturation corners
    run_op(0, 8'sh03, 8'sh05, "pos");
    run_op(0, 8'shFD, 8'sh05, "neg");
    run_op(0, 8'sh80, 8'sh80, "sat_hi");
    run_op(0, 8'sh80, 8'sh7F, "sat_lo");

    // Fixed point
    run_op(1, 8'sh40, 8'sh40, "fx_half");
    run_op(1, 8'sh7F, 8'sh81, "fx_neg");

    // Start/operand noise during BUSY, start held through DONE and into the next IDLE
    @(posedge clk); #1;
    push(0, 8'sh07, 8'sh09);
    drive(0, 1'b1, 8'sh07, 8'sh09);
    dones = 0; d1 = 0; d2 = 0;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk); #1;
      if (if0.done) begin
        dones++;
        if (d1 == 0) d1 = c;
        else         d2 = c;
        check_out(0, "ign");
      end
      if (c <= 7) drive(0, logic'(c % 2), W'($urandom), W'($urandom));
      if (c == 8) begin
        push(0, 8'sh06, 8'shF9);
        drive(0, 1'b1, 8'sh06, 8'shF9);
      end
      if (c == 10) begin
        chk("ign_idle_busy", if0.busy, 0);
        chk("ign_idle_stall", if0.stall, 1);
      end
      if (c == 11) set_start(0, 1'b0);
    end
    chk("ign_done_count", dones, 2);
    chk("ign_first_done", d1, W + 1);
    chk("ign_second_done", d2, 2 * W + 3);

    // Reset at BUSY cycle 4
    @(posedge clk); #1;
    drive(0, 1'b1, 8'sh0B, 8'sh0D);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) set_start(0, 1'b0);
    end
    chk("mid_busy_before", if0.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", if0.busy, 0);
    chk("mid_rst_done", if0.done, 0);
    chk("mid_rst_product", if0.product, 0);
    chk("mid_rst_result", if0.result, 0);
    chk("mid_rst_sat", if0.sat, 0);
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (if0.done) dones++;
    end
    chk("mid_rst_no_done", dones, 0);
    run_op(0, 8'sh02, 8'sh02, "after_rst");

    chk("sb0_drained", sbq0.size(), 0);
    chk("sb1_drained", sbq1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
